// File: rtl/keypad_scanner.sv
// 4x4 membrane keypad scanner with frame-based debounce.
// Emits one strobe per debounced press: digit, operator, backspace or equals.
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       dig_pulse,
  output logic       op_pulse,
  output logic       bksp_pulse,
  output logic       eq_pulse,
  output logic [3:0] digit,
  output logic [1:0] op_code
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] DEB_N    = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] K_DIG  = 2'd0;
  localparam logic [1:0] K_OP   = 2'd1;
  localparam logic [1:0] K_BKSP = 2'd2;
  localparam logic [1:0] K_EQ   = 2'd3;

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

  logic [3:0]       row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q;
  logic [3:0]       col_n_q;
  logic [15:0]      act_q, act_d;
  state_t           state_q;
  logic [3:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dig_q, op_q, bksp_q, eq_q;
  logic [3:0]       digit_q;
  logic [1:0]       op_code_q;

  logic       slot_end, frame_end;
  logic       act_none, act_multi, act_single;
  logic [3:0] key_now;
  logic [1:0] key_kind;
  logic [3:0] key_val;
  logic       press_done;

  function automatic logic [3:0] key_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Key index k = 4*row + col, layout 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
  function automatic logic [5:0] decode(input logic [3:0] k);
    logic [5:0] r;
    case (k)
      4'd0:    r = {K_DIG,  4'd1};
      4'd1:    r = {K_DIG,  4'd2};
      4'd2:    r = {K_DIG,  4'd3};
      4'd3:    r = {K_OP,   4'd0};
      4'd4:    r = {K_DIG,  4'd4};
      4'd5:    r = {K_DIG,  4'd5};
      4'd6:    r = {K_DIG,  4'd6};
      4'd7:    r = {K_OP,   4'd1};
      4'd8:    r = {K_DIG,  4'd7};
      4'd9:    r = {K_DIG,  4'd8};
      4'd10:   r = {K_DIG,  4'd9};
      4'd11:   r = {K_OP,   4'd2};
      4'd12:   r = {K_BKSP, 4'd0};
      4'd13:   r = {K_DIG,  4'd0};
      4'd14:   r = {K_EQ,   4'd0};
      default: r = {K_OP,   4'd3};
    endcase
    return r;
  endfunction

  assign slot_end  = (div_q == DIV_LAST);
  assign frame_end = slot_end && (col_q == 2'd3);

  // The column-3 capture is merged combinationally so the frame is classified on its last edge.
  always_comb begin
    act_d = act_q;
    if (slot_end) begin
      for (int r = 0; r < 4; r++) begin
        act_d[4*r + int'(col_q)] = ~row_sync_q[r];
      end
    end
  end

  assign act_none   = (act_d == 16'd0);
  assign act_multi  = ((act_d & (act_d - 16'd1)) != 16'd0);
  assign act_single = !act_none && !act_multi;
  assign key_now    = key_index(act_d);
  assign {key_kind, key_val} = decode(key_now);

  assign press_done = frame_end && act_single &&
                      (((state_q == IDLE) && (DEB_N == CNT_ONE)) ||
                       ((state_q == PRESS_CHK) && (key_now == cand_q) &&
                        ((cnt_q + CNT_ONE) == DEB_N)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      div_q      <= '0;
      col_q      <= 2'd0;
      col_n_q    <= 4'b1110;
      act_q      <= '0;
      state_q    <= IDLE;
      cand_q     <= 4'd0;
      cnt_q      <= '0;
      dig_q      <= 1'b0;
      op_q       <= 1'b0;
      bksp_q     <= 1'b0;
      eq_q       <= 1'b0;
      digit_q    <= 4'd0;
      op_code_q  <= 2'd0;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
      dig_q      <= 1'b0;
      op_q       <= 1'b0;
      bksp_q     <= 1'b0;
      eq_q       <= 1'b0;

      if (slot_end) begin
        div_q   <= '0;
        col_q   <= col_q + 2'd1;
        col_n_q <= {col_n_q[2:0], col_n_q[3]};
        act_q   <= act_d;
      end else begin
        div_q <= div_q + DIV_ONE;
      end

      if (frame_end) begin
        case (state_q)
          IDLE: begin
            if (act_single) begin
              cand_q  <= key_now;
              cnt_q   <= CNT_ONE;
              state_q <= press_done ? HELD : PRESS_CHK;
            end
          end
          PRESS_CHK: begin
            if (act_single && key_now == cand_q) begin
              cnt_q <= cnt_q + CNT_ONE;
              if (press_done) state_q <= HELD;
            end else if (act_single) begin
              cand_q <= key_now;
              cnt_q  <= CNT_ONE;
            end else begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end
          HELD: begin
            if (act_none) begin
              if (DEB_N == CNT_ONE) begin
                cnt_q   <= '0;
                state_q <= IDLE;
              end else begin
                cnt_q   <= CNT_ONE;
                state_q <= RELEASE_CHK;
              end
            end
          end
          default: begin
            if (!act_none) begin
              state_q <= HELD;
            end else if ((cnt_q + CNT_ONE) == DEB_N) begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        endcase
      end

      if (press_done) begin
        case (key_kind)
          K_DIG: begin
            dig_q   <= 1'b1;
            digit_q <= key_val;
          end
          K_OP: begin
            op_q      <= 1'b1;
            op_code_q <= key_val[1:0];
          end
          K_BKSP:  bksp_q <= 1'b1;
          default: eq_q   <= 1'b1;
        endcase
      end
    end
  end

  assign col_n      = col_n_q;
  assign dig_pulse  = dig_q;
  assign op_pulse   = op_q;
  assign bksp_pulse = bksp_q;
  assign eq_pulse   = eq_q;
  assign digit      = digit_q;
  assign op_code    = op_code_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 membrane keypad and debounces it. Emits the one-cycle key strobes consumed by the calculator control FSM: digit, operator, backspace and equals.
- Sits between the board keypad pins and the control block. Strobes are synchronous to the system clock.
- Produces exactly one strobe per debounced press. Nothing is emitted on hold or on release.

Parameters:
SCAN_DIV, 4, clock cycles each column is driven; rows are sampled on the last cycle of the slot (min 2)
DEBOUNCE, 3, consecutive identical frames required to accept a press or a release (min 1)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clock
col_n  output  4  keypad column drive, active-low, exactly one bit low at all times
dig_pulse  output  1  one-cycle strobe, digit key accepted
op_pulse  output  1  one-cycle strobe, operator key accepted
bksp_pulse  output  1  one-cycle strobe, backspace key accepted
eq_pulse  output  1  one-cycle strobe, equals key accepted
digit  output  4  value of last accepted digit, 0-9
op_code  output  2  last accepted operator: 0 add, 1 sub, 2 mul, 3 div

Behaviour:
- Reset (asynchronous, reset_n=0) values:
  - col_n=4'b1110, all pulses 0, digit=0, op_code=0.
  - Scan counters 0, debounce count 0, FSM in IDLE.
- Input synchronization: row_n passes through a 2-flop synchronizer. Only synchronized rows are used.
- Scan timing:
  - A divider counts 0..SCAN_DIV-1 per column. Columns are driven in order 0,1,2,3, then wrap.
  - On divider = SCAN_DIV-1, the synchronized rows are captured for the current column, and col_n rotates on the same edge.
  - One frame = 4*SCAN_DIV cycles. A frame ends when column 3 is captured.
- Frame classification at frame end:
  - NONE: no active row bit in any column.
  - SINGLE(k): exactly one active bit, with k = 4*row + col.
  - MULTI: two or more active bits.
- Key map (row 0..3 top to bottom, col 0..3 left to right):
  - 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
  - Digits 0-9 produce dig_pulse.
  - A/B/C/D produce op_pulse with op_code 0/1/2/3.
  - * produces bksp_pulse.
  - # produces eq_pulse.
- FSM, evaluated only at frame end:
  - IDLE:
    - SINGLE(k): latch candidate=k, count=1, go to PRESS_CHK. If DEBOUNCE=1, accept immediately.
    - Otherwise stay in IDLE.
  - PRESS_CHK:
    - SINGLE(same k): count+1. When count reaches DEBOUNCE, accept and go to HELD.
    - SINGLE(different k): restart with the new candidate, count=1.
    - NONE or MULTI: go to IDLE, count=0.
  - HELD:
    - NONE: count=1, go to RELEASE_CHK.
    - SINGLE or MULTI: stay in HELD. Key changes while held are ignored.
  - RELEASE_CHK:
    - NONE: count+1. When count reaches DEBOUNCE, go to IDLE.
    - Any key activity: go back to HELD.
- Accept action:
  - In the cycle after the frame-end edge that completes the count, exactly one of the four pulses is 1 for exactly one clock.
  - On that same edge, digit or op_code updates. It then holds until the next accepted key of that class.
  - bksp and eq do not change digit or op_code.
- Latency: press-to-pulse is at most (DEBOUNCE+1) frames plus 2 synchronizer cycles plus 1 cycle.
- Boundary cases:
  - A key held indefinitely gives one pulse.
  - A re-press is accepted only after a debounced release completes.
  - MULTI never produces a pulse (ghosting rejection).
  - Reset mid-frame or mid-debounce restarts scanning at column 0. A key still held after reset is accepted afresh after debounce.
  - The pulses are mutually exclusive and never asserted for two consecutive cycles.

Test Plan:
1. SCAN_DIV=4, DEBOUNCE=3; hold key 5 (row1,col1) for 10 frames -> exactly one dig_pulse, digit=5, within 4 frames of press; no further pulses while held.
2. Key 7 present on frame 1, absent on frame 2, then stable from frame 3 -> single dig_pulse with digit=7, occurring at end of 3rd stable frame +1 cycle.
3. Press A, release 3 frames, then press D -> two op_pulse, op_code=0 then 3; digit unchanged from prior value.
4. Press * then # (each with debounced release) -> one bksp_pulse, then one eq_pulse; digit and op_code unchanged.
5. Hold 1 and 2 together for 5 frames, then release 1 leaving 2 -> no pulse during MULTI; one dig_pulse digit=2 after 3 single-key frames.
6. Hold 9, assert reset_n=0 for 3 cycles mid-PRESS_CHK with 9 still held -> all outputs at reset values, col_n=1110; after release of reset, one dig_pulse digit=9 after debounce.
